// File: rtl/cp0_unit.sv
// Coprocessor-0 (SR, Cause, EPC, PRId) in M stage: arbitrates interrupts vs. exceptions, raises Req.
// Req, CP0Out and EPCOut are combinational; state updates on the next clk edge; no backpressure.
module cp0_unit #(
   parameter logic [31:0] PRID_VALUE = 32'h4D49_5053,
   parameter logic [5:0]  IM_RESET   = 6'b000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  CP0Add,
   input  logic [31:0] CP0In,
   output logic [31:0] CP0Out,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] EPCOut,
   output logic        Req
);

   localparam logic [4:0]  ADDR_SR    = 5'd12;
   localparam logic [4:0]  ADDR_CAUSE = 5'd13;
   localparam logic [4:0]  ADDR_EPC   = 5'd14;
   localparam logic [4:0]  ADDR_PRID  = 5'd15;
   localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic [31:0] victim_pc;
   logic [31:0] epc_next;
   logic [31:0] sr_word;
   logic [31:0] cause_word;
   logic        wr_sr;
   logic        wr_epc;

   assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
   assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
   assign Req     = (int_req | exc_req) & ~reset;

   // A delay-slot victim is restarted from its branch, one word earlier.
   assign victim_pc = VPC & WORD_MASK;
   assign epc_next  = BDIn ? (victim_pc - 32'd4) : victim_pc;

   assign wr_sr  = en & (CP0Add == ADDR_SR) & ~Req;
   assign wr_epc = en & (CP0Add == ADDR_EPC) & ~Req;

   assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
   assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im     <= IM_RESET;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= 6'b0;
         cause_exc <= 5'b0;
         epc       <= 32'b0;
      end else begin
         cause_ip <= HWInt;
         if (Req) begin
            sr_exl    <= 1'b1;
            cause_exc <= int_req ? 5'd0 : ExcCodeIn;
            cause_bd  <= BDIn;
            epc       <= epc_next;
         end else begin
            if (wr_sr) begin
               sr_im  <= CP0In[15:10];
               sr_exl <= CP0In[1];
               sr_ie  <= CP0In[0];
            end
            if (wr_epc) begin
               epc <= CP0In & WORD_MASK;
            end
            // eret overrides a same-cycle mtc0 to SR.EXL
            if (EXLClr) begin
               sr_exl <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      CP0Out = 32'b0;
      case (CP0Add)
         ADDR_SR:    CP0Out = sr_word;
         ADDR_CAUSE: CP0Out = cause_word;
         ADDR_EPC:   CP0Out = epc;
         ADDR_PRID:  CP0Out = PRID_VALUE;
         default:    CP0Out = 32'b0;
      endcase
   end

   // Forward a same-cycle mtc0 EPC so an immediately following eret sees it.
   assign EPCOut = wr_epc ? (CP0In & WORD_MASK) : epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against a register-word model of CP0.
module tb_cp0_unit;

   localparam logic [31:0] PRID = 32'h4D49_5053;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [4:0]  CP0Add;
   logic [31:0] CP0In;
   logic [31:0] CP0Out;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] EPCOut;
   logic        Req;

   always #5 clk = ~clk;

   cp0_unit #(.PRID_VALUE(PRID), .IM_RESET(6'b000000)) dut (
      .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
      .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
      .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
   );

   int checks = 0;
   int errors = 0;

   // Model state: architectural register words as software would read them.
   logic [31:0] m_sr, m_cause, m_epc;
   bit          model_valid = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit m_int();
      return !reset && ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic bit m_req();
      return m_int() || (!reset && (ExcCodeIn != 5'd0) && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] m_epcout();
      if (en && CP0Add == 5'd14 && !m_req()) return CP0In & 32'hFFFF_FFFC;
      return m_epc;
   endfunction

   task automatic settle();
      @(negedge clk);
      chk("req", {31'b0, Req}, {31'b0, m_req()});
      if (model_valid) begin
         chk("cp0out", CP0Out, m_read(CP0Add));
         chk("epcout", EPCOut, m_epcout());
      end
   endtask

   task automatic tick();
      bit r, intr;
      @(posedge clk);
      r    = m_req();
      intr = m_int();
      if (reset) begin
         m_sr    = 32'd0;
         m_cause = 32'd0;
         m_epc   = 32'd0;
         model_valid = 1;
      end else begin
         if (r) begin
            m_sr[1]       = 1'b1;
            m_cause[31]   = BDIn;
            m_cause[6:2]  = intr ? 5'd0 : ExcCodeIn;
            m_epc         = (VPC & 32'hFFFF_FFFC) - (BDIn ? 32'd4 : 32'd0);
         end else begin
            if (en && CP0Add == 5'd12) m_sr = CP0In & 32'h0000_FC03;
            if (en && CP0Add == 5'd14) m_epc = CP0In & 32'hFFFF_FFFC;
            if (EXLClr) m_sr[1] = 1'b0;
         end
         m_cause[15:10] = HWInt;
      end
      #1;
   endtask

   task automatic idle();
      reset = 0; en = 0; CP0Add = 5'd0; CP0In = 32'd0; VPC = 32'd0;
      BDIn = 0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      settle(); chk("rst_req", {31'b0, Req}, 32'd0);
      tick();
      CP0Add = 5'd12;
      settle(); chk("rst_sr", CP0Out, 32'd0);
      tick();

      // Interrupt taken after enabling it via mtc0 SR
      idle(); en = 1; CP0Add = 5'd12; CP0In = 32'h0000_FC01; HWInt = 6'b000100;
      settle(); chk("t1_noreq_yet", {31'b0, Req}, 32'd0);
      tick();
      en = 0; VPC = 32'h0000_3010; CP0Add = 5'd13;
      settle(); chk("t1_req", {31'b0, Req}, 32'd1);
      tick();
      settle(); chk("t1_cause", CP0Out, 32'h0000_1000);
      tick();
      CP0Add = 5'd14;
      settle(); chk("t1_epc", CP0Out, 32'h0000_3010);
      tick();
      CP0Add = 5'd12;
      settle(); chk("t1_sr", CP0Out, 32'h0000_FC03);
      tick();

      // Nested events masked while EXL=1, then eret reopens
      ExcCodeIn = 5'd10;
      settle(); chk("t3_nested", {31'b0, Req}, 32'd0);
      tick();
      ExcCodeIn = 5'd0; EXLClr = 1;
      settle(); chk("t3_eret_cycle", {31'b0, Req}, 32'd0);
      tick();
      EXLClr = 0; VPC = 32'h0000_3018;
      settle(); chk("t3_rearm", {31'b0, Req}, 32'd1);
      tick();

      // eret plus SR=0 write, then AdEL in delay slot with IE=0
      EXLClr = 1; en = 1; CP0Add = 5'd12; CP0In = 32'd0; HWInt = 6'd0;
      settle();
      tick();
      EXLClr = 0; en = 0; ExcCodeIn = 5'd4; BDIn = 1; VPC = 32'h0000_3024;
      settle(); chk("t2_req", {31'b0, Req}, 32'd1);
      tick();
      ExcCodeIn = 5'd0; BDIn = 0; CP0Add = 5'd14;
      settle(); chk("t2_epc", CP0Out, 32'h0000_3020);
      tick();
      CP0Add = 5'd13;
      settle(); chk("t2_cause", CP0Out, 32'h8000_0010);
      tick();

      // mtc0 EPC forwarding
      en = 1; CP0Add = 5'd14; CP0In = 32'h0000_3047;
      settle(); chk("t4_fwd", EPCOut, 32'h0000_3044);
      tick();
      en = 0;
      settle(); chk("t4_mfc0", CP0Out, 32'h0000_3044);
      tick();

      // mtc0 SR suppressed by a simultaneous interrupt
      EXLClr = 1; en = 1; CP0Add = 5'd12; CP0In = 32'h0000_FC01;
      settle();
      tick();
      EXLClr = 0; HWInt = 6'b000001; CP0In = 32'd0;
      settle(); chk("t5_req", {31'b0, Req}, 32'd1);
      tick();
      en = 0;
      settle(); chk("t5_sr", CP0Out, 32'h0000_FC03);
      tick();
      CP0Add = 5'd15;
      settle(); chk("t5_prid", CP0Out, PRID);
      tick();
      CP0Add = 5'd7;
      settle(); chk("t5_other", CP0Out, 32'd0);
      tick();

      // Reset mid-handler
      reset = 1; ExcCodeIn = 5'd5;
      settle(); chk("t6_req_rst", {31'b0, Req}, 32'd0);
      tick();
      reset = 0; ExcCodeIn = 5'd0; HWInt = 6'd0; CP0Add = 5'd12;
      settle(); chk("t6_sr", CP0Out, 32'd0);
      tick();
      CP0Add = 5'd13;
      settle(); chk("t6_cause", CP0Out, 32'd0);
      tick();
      CP0Add = 5'd14;
      settle(); chk("t6_epc", CP0Out, 32'd0);
      tick();

      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 199) == 0);
         en        = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 4))
            0: CP0Add = 5'd12;
            1: CP0Add = 5'd13;
            2: CP0Add = 5'd14;
            3: CP0Add = 5'd15;
            default: CP0Add = 5'($urandom);
         endcase
         CP0In     = $urandom;
         VPC       = $urandom;
         BDIn      = 1'($urandom);
         ExcCodeIn = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
         HWInt     = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
         EXLClr    = ($urandom_range(0, 5) == 0);
         settle();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
